// File: rtl/ex_div_stage_if.sv
// rtl/ex_div_stage_if.sv - ID/EX operand fields in, EX/MEM write-back fields out
interface ex_div_stage_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        aluop_i;
    logic [2:0]        alusel_i;
    logic [DATA_W-1:0] reg1_i;
    logic [DATA_W-1:0] reg2_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [DATA_W-1:0] wdata_o;
    logic              whilo_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              stallreq_o;

    // master is the ID/EX register side, slave is the execute stage
    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_div_stage.sv
// rtl/ex_div_stage.sv - execute stage: single-cycle ALU plus multi-cycle restoring divider
module ex_div_stage #(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    ex_div_stage_if.slave  ex
);
    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t state, state_nxt;

    logic [DATA_W-1:0] logic_res, shift_res, arith_res, alu_res;
    logic [SH_W-1:0]   shamt;

    logic              is_div, is_divs, div_by_zero, op1_neg, op2_neg;
    logic [DATA_W-1:0] abs1, abs2;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo, rem, divisor;
    logic              q_neg, r_neg;
    logic [DATA_W:0]   shifted, trial;

    assign shamt = ex.reg1_i[SH_W-1:0];

    always_comb begin
        logic_res = '0;
        case (ex.aluop_i)
            EXE_AND_OP: logic_res = ex.reg1_i & ex.reg2_i;
            EXE_OR_OP:  logic_res = ex.reg1_i | ex.reg2_i;
            EXE_XOR_OP: logic_res = ex.reg1_i ^ ex.reg2_i;
            EXE_NOR_OP: logic_res = ~(ex.reg1_i | ex.reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (ex.aluop_i)
            EXE_SLL_OP: shift_res = ex.reg2_i << shamt;
            EXE_SRL_OP: shift_res = ex.reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $unsigned($signed(ex.reg2_i) >>> shamt);
            default:    shift_res = '0;
        endcase
    end

    // no overflow trap: ADD and ADDU (SUB and SUBU) share one modulo adder
    always_comb begin
        arith_res = '0;
        case (ex.aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP: arith_res = ex.reg1_i + ex.reg2_i;
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = ex.reg1_i - ex.reg2_i;
            EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
            EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, ex.reg1_i < ex.reg2_i};
            default:     arith_res = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ex.alusel_i)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            EXE_RES_ARITH: alu_res = arith_res;
            default:       alu_res = '0;
        endcase
    end

    assign ex.wd_o    = rst ? 5'd0 : ex.wd_i;
    assign ex.wreg_o  = rst ? 1'b0 : ex.wreg_i;
    assign ex.wdata_o = rst ? '0   : alu_res;

    assign is_div      = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_DIVU_OP);
    assign is_divs     = (ex.aluop_i == EXE_DIV_OP);
    assign div_by_zero = (ex.reg2_i == '0);
    assign op1_neg     = is_divs & ex.reg1_i[DATA_W-1];
    assign op2_neg     = is_divs & ex.reg2_i[DATA_W-1];
    assign abs1        = op1_neg ? -ex.reg1_i : ex.reg1_i;
    assign abs2        = op2_neg ? -ex.reg2_i : ex.reg2_i;

    // remainder < divisor keeps the shifted value below 2*divisor, so bit DATA_W of trial is the borrow
    assign shifted = {rem, quo[DATA_W-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_div) state_nxt = div_by_zero ? DONE : BUSY;
            BUSY: if (cnt == LAST_STEP) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (is_div) begin
                    cnt <= '0;
                    if (div_by_zero) begin
                        quo     <= '1;
                        rem     <= ex.reg1_i;
                        divisor <= '0;
                        q_neg   <= 1'b0;
                        r_neg   <= 1'b0;
                    end else begin
                        quo     <= abs1;
                        rem     <= '0;
                        divisor <= abs2;
                        q_neg   <= op1_neg ^ op2_neg;
                        r_neg   <= op1_neg;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (!trial[DATA_W]) begin
                        rem <= trial[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ex.stallreq_o = 1'b0;
        ex.whilo_o    = 1'b0;
        ex.hi_o       = '0;
        ex.lo_o       = '0;
        if (!rst) begin
            case (state)
                IDLE: ex.stallreq_o = is_div;
                BUSY: ex.stallreq_o = 1'b1;
                DONE: begin
                    ex.whilo_o = 1'b1;
                    ex.lo_o    = q_neg ? -quo : quo;
                    ex.hi_o    = r_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end
endmodule
